// File: rtl/i2c_target.sv
// I2C target endpoint: oversamples SCL/SDA on clk, matches a fixed 7-bit address,
// strobes out written bytes and serves read bytes from tx_data. SDA is open-drain.
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_WAIT_STOP
    } state_t;

    logic       scl_s1_q, scl_s2_q, scl_prev_q;
    logic       sda_s1_q, sda_s2_q, sda_prev_q;
    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       rw_q, rw_d;
    logic       phase_q, phase_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_load_c;

    logic       scl_rise, scl_fall, sda_rise, sda_fall;
    logic       start_det, stop_det;
    logic [7:0] byte_in;

    assign i2c_sda  = sda_oe_q ? 1'b0 : 1'bz;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign tx_load  = tx_load_c & ~rst;

    assign scl_rise  = scl_s2_q & ~scl_prev_q;
    assign scl_fall  = ~scl_s2_q & scl_prev_q;
    assign sda_rise  = sda_s2_q & ~sda_prev_q;
    assign sda_fall  = ~sda_s2_q & sda_prev_q;
    assign start_det = sda_fall & scl_s2_q;
    assign stop_det  = sda_rise & scl_s2_q;
    assign byte_in   = {shift_q[6:0], sda_s2_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= S_IDLE;
            cnt_q      <= 3'd7;
            rw_q       <= 1'b0;
            phase_q    <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
        end else begin
            scl_s1_q   <= i2c_scl;
            scl_s2_q   <= scl_s1_q;
            scl_prev_q <= scl_s2_q;
            sda_s1_q   <= i2c_sda;
            sda_s2_q   <= sda_s1_q;
            sda_prev_q <= sda_s2_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rw_q       <= rw_d;
            phase_q    <= phase_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
        shift_q <= shift_d;
    end

    // phase_q marks the second half of an ACK slot (ACK driven / master ACK seen)
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        phase_d    = phase_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_load_c  = 1'b0;

        if (stop_det) begin
            state_d  = S_IDLE;
            cnt_d    = 3'd7;
            phase_d  = 1'b0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            state_d  = S_ADDR;
            cnt_d    = 3'd7;
            phase_d  = 1'b0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        if (cnt_q == 3'd0) begin
                            cnt_d   = 3'd7;
                            rw_d    = sda_s2_q;
                            phase_d = 1'b0;
                            if (byte_in[7:1] == TARGET_ADDR) begin
                                state_d = S_ADDR_ACK;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = S_WAIT_STOP;
                            end
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            cnt_d   = 3'd7;
                            if (!rw_q) begin
                                state_d  = S_WR_DATA;
                                sda_oe_d = 1'b0;
                            end else begin
                                state_d   = S_RD_DATA;
                                tx_load_c = 1'b1;
                                shift_d   = tx_data;
                                sda_oe_d  = ~tx_data[7];
                            end
                        end
                    end
                end
                S_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        if (cnt_q == 3'd0) begin
                            cnt_d      = 3'd7;
                            rx_data_d  = byte_in;
                            rx_valid_d = 1'b1;
                            phase_d    = 1'b0;
                            state_d    = S_WR_ACK;
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                        end
                    end
                end
                S_WR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            phase_d  = 1'b0;
                            state_d  = S_WR_DATA;
                        end
                    end
                end
                S_RD_DATA: begin
                    // Bit 7 of shift_q is on the bus; rotate so the next bit sits at [7]
                    if (scl_fall) begin
                        if (cnt_q == 3'd0) begin
                            sda_oe_d = 1'b0;
                            cnt_d    = 3'd7;
                            phase_d  = 1'b0;
                            state_d  = S_RD_ACK;
                        end else begin
                            cnt_d    = cnt_q - 3'd1;
                            shift_d  = {shift_q[6:0], shift_q[7]};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s2_q) begin
                            state_d  = S_WAIT_STOP;
                            sda_oe_d = 1'b0;
                            busy_d   = 1'b0;
                        end else begin
                            phase_d = 1'b1;
                        end
                    end else if (scl_fall && phase_q) begin
                        phase_d   = 1'b0;
                        cnt_d     = 3'd7;
                        tx_load_c = 1'b1;
                        shift_d   = tx_data;
                        sda_oe_d  = ~tx_data[7];
                        state_d   = S_RD_DATA;
                    end
                end
                default: begin
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

endmodule
